// File: rtl/pes_traffic_pkg.sv
// pes_traffic_pkg: light encodings and farm-sensor FSM states shared with pes_traffic
package pes_traffic_pkg;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAITING = 2'd1;
  localparam logic [1:0] S_PASSING = 2'd2;
  function automatic logic light_valid(input logic [2:0] l);
    return l == LIGHT_RED || l == LIGHT_YELLOW || l == LIGHT_GREEN;
  endfunction
endpackage

// File: rtl/pes_farm_sensor_if.sv
// pes_farm_sensor_if: loop/light inputs and vehicle-queue outputs of the farm sensor
interface pes_farm_sensor_if #(parameter int CNT_W = 4);
  logic             loop_raw;
  logic [2:0]       light_farm;
  logic             sensor;
  logic [CNT_W-1:0] car_count;
  logic             arrival_pulse;
  logic             overflow;
  logic             light_err;
  modport master (output loop_raw, light_farm,
                  input  sensor, car_count, arrival_pulse, overflow, light_err);
  modport slave  (input  loop_raw, light_farm,
                  output sensor, car_count, arrival_pulse, overflow, light_err);
endinterface

// File: rtl/pes_debounce.sv
// pes_debounce: 2-flop synchronizer plus stability counter; rise flags the edge where dout goes high
module pes_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic          r_sync1, r_sync2, r_clean;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_flip;
  assign w_diff = r_sync2 != r_clean;
  assign w_flip = w_diff && r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  // rise is asserted in the cycle before the clean level rises so the owner can register it
  assign rise   = w_flip && r_sync2;
  assign dout   = r_clean;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_clean <= w_flip ? r_sync2 : r_clean;
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/pes_farm_sensor.sv
// pes_farm_sensor: debounced farm-road vehicle queue, retired while the farm light is green
module pes_farm_sensor import pes_traffic_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int PASS_CYCLES     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pes_farm_sensor_if.slave   bus
);
  localparam int TW = PASS_CYCLES > 1 ? $clog2(PASS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic             w_rise, w_loop_unused, w_green, w_active, w_dep, w_sat_arr;
  logic [1:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic [TW-1:0]    r_timer, w_timer_nx;
  logic             r_arrival, r_overflow, r_light_err;
  pes_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.loop_raw),
    .dout (w_loop_unused),
    .rise (w_rise)
  );
  // green time accrues only while someone waits; any non-green light restarts it
  always_comb begin
    w_green    = bus.light_farm == LIGHT_GREEN;
    w_active   = r_state != S_IDLE && w_green && r_count != '0;
    w_dep      = w_active && r_timer == TW'(PASS_CYCLES - 1);
    w_sat_arr  = w_rise && !w_dep && r_count == CNT_MAX;
    w_timer_nx = (w_active && !w_dep) ? r_timer + 1'b1 : '0;
    w_count_nx = (w_rise && !w_dep && r_count != CNT_MAX) ? r_count + 1'b1 :
                 (w_dep && !w_rise) ? r_count - 1'b1 : r_count;
    w_state_nx = w_count_nx == '0 ? S_IDLE :
                 r_state == S_IDLE ? S_WAITING :
                 w_green ? S_PASSING : S_WAITING;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_timer     <= '0;
      r_arrival   <= 1'b0;
      r_overflow  <= 1'b0;
      r_light_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_timer     <= w_timer_nx;
      r_arrival   <= w_rise;
      r_overflow  <= r_overflow | w_sat_arr;
      r_light_err <= !light_valid(bus.light_farm);
    end
  end
  assign bus.sensor        = r_count != '0;
  assign bus.car_count     = r_count;
  assign bus.arrival_pulse = r_arrival;
  assign bus.overflow      = r_overflow;
  assign bus.light_err     = r_light_err;
endmodule

// File: tb/tb_pes_farm_sensor.sv
// tb_pes_farm_sensor: directed plus randomized stimulus against a cycle-level queue model
module tb_pes_farm_sensor;
  import pes_traffic_pkg::*;
  localparam int D = 4, PASS = 8, MAXC = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  pes_farm_sensor_if #(.CNT_W(4)) bus();
  pes_farm_sensor #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .PASS_CYCLES(PASS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int checks = 0, errors = 0;
  bit m_s1, m_s2, m_clean, m_arr, m_ovf, m_err;
  int m_run, m_g, m_cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    {m_s1, m_s2, m_clean, m_arr, m_ovf, m_err} = '0;
    m_run = 0; m_g = 0; m_cnt = 0;
  endtask
  // a level is accepted after D consecutive disagreeing synchronized samples;
  // one vehicle leaves per PASS green cycles spent with a non-empty queue
  task automatic model_step();
    bit dep;
    dep = 0;
    m_arr = 0;
    if (m_s2 != m_clean) begin
      m_run++;
      if (m_run == D) begin m_clean = m_s2; m_run = 0; m_arr = m_clean; end
    end else m_run = 0;
    if (m_cnt != 0 && bus.light_farm == LIGHT_GREEN) begin
      m_g++;
      if (m_g == PASS) begin dep = 1; m_g = 0; end
    end else m_g = 0;
    if (m_arr && !dep) begin
      if (m_cnt == MAXC) m_ovf = 1; else m_cnt++;
    end else if (dep && !m_arr) m_cnt--;
    m_err = !(bus.light_farm inside {LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN});
    m_s2 = m_s1;
    m_s1 = bus.loop_raw;
  endtask
  task automatic check_all();
    chk("sensor", bus.sensor, m_cnt != 0);
    chk("car_count", bus.car_count, m_cnt);
    chk("arrival_pulse", bus.arrival_pulse, m_arr);
    chk("overflow", bus.overflow, m_ovf);
    chk("light_err", bus.light_err, m_err);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic arrive();
    bus.loop_raw = 1'b1;
    ticks(6);
    bus.loop_raw = 1'b0;
    ticks(8);
  endtask
  initial begin
    model_reset();
    bus.loop_raw = 1'b0;
    bus.light_farm = LIGHT_RED;
    // reset holds everything at zero whatever the inputs do
    for (int i = 0; i < 4; i++) begin
      bus.loop_raw = i[0];
      bus.light_farm = i[1] ? LIGHT_GREEN : 3'b111;
      tick();
    end
    bus.loop_raw = 1'b0;
    bus.light_farm = LIGHT_RED;
    rst_n = 1'b1;
    ticks(4);
    // arrival latency: clean level and count move on the sixth edge
    bus.loop_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("lat_pulse", bus.arrival_pulse, i == 6);
    end
    chk("lat_count", bus.car_count, 1);
    chk("lat_sensor", bus.sensor, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_no_pulse", bus.arrival_pulse, 0);
    end
    bus.loop_raw = 1'b0;
    ticks(8);
    // glitch rejection then minimum accepted pulse
    bus.loop_raw = 1'b1;
    ticks(3);
    bus.loop_raw = 1'b0;
    ticks(10);
    chk("glitch_count", bus.car_count, 1);
    bus.loop_raw = 1'b1;
    ticks(4);
    bus.loop_raw = 1'b0;
    ticks(10);
    chk("min_pulse_count", bus.car_count, 2);
    // departures while green
    arrive();
    chk("three_waiting", bus.car_count, 3);
    bus.light_farm = LIGHT_GREEN;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 8) chk("dep_8", bus.car_count, 2);
      if (i == 16) chk("dep_16", bus.car_count, 1);
    end
    chk("dep_20", bus.car_count, 1);
    bus.light_farm = LIGHT_RED;
    ticks(3);
    bus.light_farm = LIGHT_GREEN;
    ticks(8);
    chk("empty_count", bus.car_count, 0);
    chk("empty_sensor", bus.sensor, 0);
    chk("fsm_idle", dut.r_state, S_IDLE);
    // fill to saturation
    bus.light_farm = LIGHT_RED;
    repeat (MAXC) arrive();
    chk("sat_count", bus.car_count, MAXC);
    chk("sat_no_ovf", bus.overflow, 0);
    // arrival lands on the departure edge: count holds, no overflow
    bus.light_farm = LIGHT_GREEN;
    ticks(2);
    bus.loop_raw = 1'b1;
    ticks(6);
    chk("coinc_pulse", bus.arrival_pulse, 1);
    chk("coinc_count", bus.car_count, MAXC);
    chk("coinc_no_ovf", bus.overflow, 0);
    bus.light_farm = LIGHT_RED;
    bus.loop_raw = 1'b0;
    ticks(8);
    arrive();
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_count", bus.car_count, MAXC);
    // invalid light during passing drops back to waiting and loses partial time
    bus.light_farm = LIGHT_GREEN;
    ticks(3);
    chk("fsm_passing", dut.r_state, S_PASSING);
    bus.light_farm = 3'b011;
    tick();
    chk("bad_light_err", bus.light_err, 1);
    chk("bad_light_fsm", dut.r_state, S_WAITING);
    chk("bad_light_count", bus.car_count, MAXC);
    bus.light_farm = LIGHT_GREEN;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("regreen_count", bus.car_count, i == 8 ? MAXC - 1 : MAXC);
    end
    chk("err_not_sticky", bus.light_err, 0);
    // randomized traffic and lights
    for (int s = 0; s < 80; s++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.loop_raw = 1'($urandom_range(0, 1));
      bus.light_farm = r < 4 ? LIGHT_GREEN : r < 6 ? LIGHT_RED :
                       r < 8 ? LIGHT_YELLOW : 3'($urandom_range(0, 7));
      ticks($urandom_range(1, 8));
    end
    // asynchronous reset mid-count clears the queue without a clock edge
    bus.loop_raw = 1'b0;
    bus.light_farm = LIGHT_RED;
    ticks(8);
    arrive();
    chk("pre_reset_count", bus.car_count, m_cnt);
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", bus.car_count, 0);
    chk("async_rst_sensor", bus.sensor, 0);
    chk("async_rst_ovf", bus.overflow, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ticks(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
